// File: rtl/key_event_gen_if.sv
// key_event_gen_if: raw key pins in, debounced level and event pulses out
interface key_event_gen_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_repeat;
    modport master (output key_n, input key_level, key_press, key_release, key_repeat);
    modport slave (input key_n, output key_level, key_press, key_release, key_repeat);
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen: per-key synchronise, debounce, press/release pulses and auto-repeat
module key_event_gen #(
    parameter int N_KEYS = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC = 5_000_000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = 4'b1100
) (
    input logic clk,
    input logic rstn,
    key_event_gen_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
    localparam int RMAX = REPEAT_DELAY_CYC > REPEAT_RATE_CYC ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int RW = $clog2(RMAX) + 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYC - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t state [N_KEYS];
    logic [DW-1:0] dcnt [N_KEYS];
    logic [RW-1:0] rcnt [N_KEYS];
    logic [N_KEYS-1:0] sync1, sync2, repeating;
    logic [N_KEYS-1:0] lvl_q, prs_q, rel_q, rep_q;

    // two-flop synchroniser on the inverted pins, 1 = pressed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~bus.key_n;
            sync2 <= sync1;
        end
    end

    // independent debounce/repeat FSM per key, producing event flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < N_KEYS; k++) begin
                state[k] <= RELEASED;
                dcnt[k] <= '0;
                rcnt[k] <= '0;
            end
            repeating <= '0;
            lvl_q <= '0;
            prs_q <= '0;
            rel_q <= '0;
            rep_q <= '0;
        end else begin
            prs_q <= '0;
            rel_q <= '0;
            rep_q <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                case (state[k])
                    RELEASED: begin
                        if (sync2[k]) begin
                            state[k] <= PRESS_WAIT;
                            dcnt[k] <= DW'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2[k]) begin
                            state[k] <= RELEASED;
                        end else if (dcnt[k] == D_LAST) begin
                            state[k] <= PRESSED;
                            lvl_q[k] <= 1'b1;
                            prs_q[k] <= 1'b1;
                            rcnt[k] <= '0;
                        end else begin
                            dcnt[k] <= dcnt[k] + DW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync2[k]) begin
                            state[k] <= RELEASE_WAIT;
                            dcnt[k] <= DW'(1);
                        end else if (REPEAT_MASK[k]) begin
                            if (rcnt[k] == (repeating[k] ? RATE_LAST : DELAY_LAST)) begin
                                prs_q[k] <= 1'b1;
                                rep_q[k] <= 1'b1;
                                rcnt[k] <= '0;
                                repeating[k] <= 1'b1;
                            end else begin
                                rcnt[k] <= rcnt[k] + RW'(1);
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2[k]) begin
                            state[k] <= PRESSED;
                        end else if (dcnt[k] == D_LAST) begin
                            state[k] <= RELEASED;
                            lvl_q[k] <= 1'b0;
                            rel_q[k] <= 1'b1;
                            repeating[k] <= 1'b0;
                        end else begin
                            dcnt[k] <= dcnt[k] + DW'(1);
                        end
                    end
                    default: state[k] <= RELEASED;
                endcase
            end
        end
    end

    // output register stage so every output comes straight from a flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.key_level <= '0;
            bus.key_press <= '0;
            bus.key_release <= '0;
            bus.key_repeat <= '0;
        end else begin
            bus.key_level <= lvl_q;
            bus.key_press <= prs_q;
            bus.key_release <= rel_q;
            bus.key_repeat <= rep_q;
        end
    end
endmodule

// File: doc/key_event_gen.md
# key_event_gen

Upstream key-conditioning stage for the multi-mode clock's push-button inputs. It takes the raw active-low KEY pins and drives the mode FSM and the increase/decrease logic. Per key it synchronises, debounces and edge-detects the input, then produces single-cycle press and release pulses. On keys enabled for it, a held key also generates auto-repeat press pulses, so hour/minute/second adjustment advances continuously while KEY[2]/KEY[3] are held. All keys are processed independently on the 50 MHz system clock.

## Interface
- N_KEYS, 4: number of keys handled.
- DEBOUNCE_CYC, 1_000_000: consecutive stable samples required to accept a level change; legal range ≥ 2.
- REPEAT_DELAY_CYC, 25_000_000: cycles from a press pulse to the first auto-repeat pulse; legal range ≥ 2.
- REPEAT_RATE_CYC, 5_000_000: cycles between subsequent auto-repeat pulses; legal range ≥ 2.
- REPEAT_MASK, 4'b1100: bit i = 1 enables auto-repeat on key i. Default enables increase/decrease only.
- clk  input  1  system clock (CLOCK_50).
- rstn  input  1  reset; **one clock; reset is asynchronous and active-low**.
- key_n  input  N_KEYS  raw key pins, low = pressed, asynchronous to clk.
- key_level  output  N_KEYS  debounced state, 1 = pressed.
- key_press  output  N_KEYS  1-cycle pulse on accepted press and on each auto-repeat.
- key_release  output  N_KEYS  1-cycle pulse on accepted release.
- key_repeat  output  N_KEYS  high in the same cycle as key_press when that pulse is an auto-repeat, not the initial press.

## Operation
- **Synchroniser.** Per key, a 2-flop synchroniser on ~key_n gives sample s (1 = pressed). Both flops reset to 0.
- **Per-key FSM.** States RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, each with a debounce counter dcnt and a repeat counter rcnt. Counter widths are $clog2 of their largest parameter plus 1.
- **RELEASED**
  - s=1: go to PRESS_WAIT, dcnt=1.
  - Otherwise stay.
- **PRESS_WAIT**
  - s=0: return to RELEASED with no pulse; the glitch is rejected.
  - s=1 and dcnt=DEBOUNCE_CYC-1: go to PRESSED, set key_level=1, pulse key_press, rcnt=0.
  - Otherwise dcnt++.
- **PRESSED**
  - s=0: go to RELEASE_WAIT, dcnt=1. rcnt is frozen.
  - Otherwise, if REPEAT_MASK[i]=1, rcnt++.
  - When rcnt reaches REPEAT_DELAY_CYC-1 (first repeat) or REPEAT_RATE_CYC-1 (later repeats): pulse key_press and key_repeat, clear rcnt, mark "repeating".
  - If REPEAT_MASK[i]=0, rcnt stays 0 and no repeats occur.
- **RELEASE_WAIT**
  - s=1: return to PRESSED with no pulse; rcnt and "repeating" are retained.
  - s=0 and dcnt=DEBOUNCE_CYC-1: go to RELEASED, set key_level=0, pulse key_release, clear "repeating".
  - Otherwise dcnt++.
- All outputs are registered.
- Keys are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle; there is no priority or masking.
- key_level is constant between pulses: it rises in the key_press cycle of the initial press and falls in the key_release cycle.

## Timing
- Reset (rstn=0, asynchronous): every FSM in RELEASED, all counters 0, synchronisers 0. Outputs key_level, key_press, key_release and key_repeat are all 0.
- Reset deassertion is used synchronously; the first state update occurs on the first clk edge with rstn=1.
- Reset mid-press drops key_level immediately, with no key_release pulse. A key still held after reset requires a full DEBOUNCE_CYC qualification before key_press.
- **Press latency.** Suppose key_n is low and stable, first sampled at edge E. Then key_press is high for exactly one cycle, starting at edge E+DEBOUNCE_CYC+2.
- **Release latency.** Symmetric to press latency, with key_release.
- **Auto-repeat timing.**
  - First repeat pulse starts exactly REPEAT_DELAY_CYC cycles after the initial press pulse.
  - Subsequent repeat pulses follow every REPEAT_RATE_CYC cycles while held.
  - A bounce absorbed in RELEASE_WAIT delays the next repeat by the time spent there.
- Pulses are never wider than one cycle. No key emits key_press and key_release in the same cycle.

## Test plan
All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, N_KEYS=4.

- **Reset values.** Assert rstn=0 mid-simulation with key 2 held → all outputs 0 at once. Release rstn with key 2 still low → key_press[2] appears 6 edges later, with no release pulse in between.
- **Clean press/release, key 0.** Drive key_n[0] low at edge 10 and high at edge 40:
  - key_press[0] is high only at cycle 16.
  - key_level[0] is 1 from cycle 16.
  - key_release[0] is high only at cycle 46; key_level[0] returns to 0 there.
  - key_repeat stays 0 throughout.
- **Glitch rejection, key 1.** Drive key_n[1] low for 3 cycles, then high → no pulses and key_level[1] stays 0. Repeat with a 3-cycle-high bounce while pressed → no release and no extra press.
- **Auto-repeat, key 2.** Hold key_n[2] low for 50 cycles after the press pulse at cycle P:
  - key_press[2] at P, P+20, P+25, P+30, P+35, P+40, P+45.
  - key_repeat[2] on all of these except P.
- **No repeat on masked key 0.** Hold key_n[0] for 100 cycles → exactly one key_press[0].
- **Simultaneous keys 2 and 3.** Drive both low at the same edge → key_press[2] and key_press[3] in the same cycle, with identical repeat cadence. Release key 3 only → key 2 repeats continue undisturbed.
